bg_rom_responder: RTL and testbench
===================================

Name: bg_rom_responder

Overview:
- Memory-side responder for the two background-layer tile ROM fetch channels (A and B).
- Each layer raises toggle-handshake requests on its channel. This block arbitrates between them and issues single 32-bit reads to the SDRAM controller read port.
- It returns the data and completes each channel's handshake.
- It sits between the background board and the SDRAM controller, one instance per video board.

Parameters:
- ADDR_W, 25, byte address width on the request channels and the memory port.
- MEM_TIMEOUT, 0, cycles to wait for mem_dv before force-completing a request with zero data; 0 disables the timeout.

Ports:
- CLK_32M  input  1  system clock; every register uses its rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- sdr_addr_a  input  ADDR_W  channel A byte address.
- sdr_req_a  input  1  channel A request toggle.
- sdr_ack_a  output  1  channel A acknowledge toggle.
- sdr_data_a  output  32  channel A read data.
- sdr_addr_b  input  ADDR_W  channel B byte address.
- sdr_req_b  input  1  channel B request toggle.
- sdr_ack_b  output  1  channel B acknowledge toggle.
- sdr_data_b  output  32  channel B read data.
- mem_addr  output  ADDR_W  read address to the SDRAM controller; bits [1:0] always 0.
- mem_req  output  1  read request level.
- mem_gnt  input  1  controller accepted the request (1-cycle pulse).
- mem_dv  input  1  read data valid (1-cycle pulse).
- mem_dout  input  32  read data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, CLK_32M. RESET_N is asynchronous and active-low.
- Reset values:
  - sdr_ack_a = 0, sdr_ack_b = 0.
  - sdr_data_a = 0, sdr_data_b = 0.
  - mem_req = 0, mem_addr = 0, busy = 0.
  - FSM = IDLE, last-served pointer = B (so A wins the first tie).
- Pending condition: channel X is pending when sdr_req_x != sdr_ack_x.
  - The requester toggles req only when req == ack.
  - req/addr changes while pending are a protocol violation and are ignored.
  - The address is captured at issue.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If exactly one channel is pending, select it.
  - If both are pending, select the channel that is not the last-served one (round-robin).
  - On the next edge: latch {addr[ADDR_W-1:2],2'b00} into mem_addr, assert mem_req, record the selected channel, go to ISSUE.
  - Latency: the req toggle is sampled, and mem_req is high 1 cycle later.
- ISSUE:
  - Hold mem_req and mem_addr stable until mem_gnt is sampled high.
  - On that edge: deassert mem_req, go to WAIT.
  - mem_dv in the same cycle as mem_gnt is legal. In that case, complete the request as WAIT does, going directly to IDLE.
- WAIT:
  - On the edge where mem_dv is sampled high, in one edge:
    - the selected channel's sdr_data ← mem_dout;
    - its sdr_ack ← its sdr_req;
    - the last-served pointer is updated;
    - go to IDLE.
  - Data and ack change on the same edge, so the requester sees valid data whenever ack == req.
- Non-selected channel: its data and ack are never modified.
- Back-to-back: from IDLE after a completion, a pending request on the other channel is issued on the very next edge. No dead cycle beyond IDLE.
- Stray mem_dv: a mem_dv in IDLE or ISSUE without a prior grant is ignored.
- Timeout: if MEM_TIMEOUT > 0 and WAIT lasts MEM_TIMEOUT cycles, complete the request with data 0 and return to IDLE.
  - Timeout counter width is ceil(log2(MEM_TIMEOUT+1)); it saturates and is cleared on entry to WAIT.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - A mem_dv arriving afterwards is dropped as stray.
  - Requesters see ack == 0 and must re-toggle.

Optional Feature:
- Macro: BG_ROM_RESPONDER_HIT_CACHE_EN.
- When defined:
  - Each channel keeps a valid bit and a tag: the last completed word address plus its data.
  - In IDLE, a selected channel whose word address matches its valid tag completes on the next edge: data reloaded from the tag, ack toggled, no mem_req, and the last-served pointer still updates.
  - The valid bits clear on reset.
- When not defined: every request goes through the memory port; no tag storage is synthesised.

Test Plan:
- Single A read:
  - Stimulus: sdr_addr_a = 0x0001236 (low bits deliberately non-zero), toggle req_a 0→1; controller grants 2 cycles after mem_req, mem_dv with 0xDEADBEEF 4 cycles later.
  - Required: mem_addr = 0x0001234; mem_req high 1 cycle after the toggle; ack_a = 1 and data_a = 0xDEADBEEF on the edge after mem_dv; B untouched.
- Simultaneous A and B after reset:
  - Required: A served first, then B issued on the next edge after A completes; the next simultaneous pair is served B first.
- Grant and dv in the same cycle:
  - Required: completion occurs with no WAIT cycle; busy drops one cycle after.
- Reset asserted during WAIT, then mem_dv pulse:
  - Required: acks stay 0, data stays 0, mem_req stays 0.
- MEM_TIMEOUT = 8, no mem_dv:
  - Required: ack toggles 8 cycles after entering WAIT with data 0x00000000.
- With BG_ROM_RESPONDER_HIT_CACHE_EN, A reads 0x100 twice:
  - Required: the second read sees ack 1 cycle after the toggle, with identical data and no mem_req.
  - Without the macro: the second read issues mem_req.

Source files
------------

// File: rtl/bg_rom_responder_if.sv
// Purpose: bundle of the two tile-ROM toggle-handshake channels plus the SDRAM read port.
// Latency: none (wires only).
// Backpressure: none here; channels use req/ack toggles, memory port uses req/gnt/dv.
// Modports: slave = the responder, master = the requesters and SDRAM controller side.
interface bg_rom_responder_if #(
  parameter int ADDR_W = 25
);
  // Channel A (background layer A)
  logic [ADDR_W-1:0] sdr_addr_a;
  logic              sdr_req_a;
  logic              sdr_ack_a;
  logic [31:0]       sdr_data_a;
  // Channel B (background layer B)
  logic [ADDR_W-1:0] sdr_addr_b;
  logic              sdr_req_b;
  logic              sdr_ack_b;
  logic [31:0]       sdr_data_b;
  // SDRAM controller read port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_dv;
  logic [31:0]       mem_dout;
  // Status
  logic              busy;

  modport slave (
    input  sdr_addr_a, sdr_req_a, sdr_addr_b, sdr_req_b,
    input  mem_gnt, mem_dv, mem_dout,
    output sdr_ack_a, sdr_data_a, sdr_ack_b, sdr_data_b,
    output mem_addr, mem_req, busy
  );

  modport master (
    output sdr_addr_a, sdr_req_a, sdr_addr_b, sdr_req_b,
    output mem_gnt, mem_dv, mem_dout,
    input  sdr_ack_a, sdr_data_a, sdr_ack_b, sdr_data_b,
    input  mem_addr, mem_req, busy
  );
endinterface

// File: rtl/bg_rom_responder.sv
// Purpose: round-robin responder serving tile-ROM channels A/B with single 32-bit SDRAM reads.
// Latency: req toggle -> mem_req 1 cycle; mem_dv -> data+ack 1 cycle (hit: toggle -> ack 1 cycle).
// Backpressure: mem_req held until mem_gnt; a second request waits pending until IDLE.
// Ports: CLK_32M / RESET_N (async active-low) plain; everything else through bus (slave modport):
//   sdr_addr_x/sdr_req_x in, sdr_ack_x/sdr_data_x out per channel; mem_addr/mem_req out,
//   mem_gnt/mem_dv/mem_dout in; busy out (high whenever the FSM is not IDLE).
// Optional: define BG_ROM_RESPONDER_HIT_CACHE_EN for a one-word per-channel hit cache.
module bg_rom_responder #(
  parameter int ADDR_W      = 25,
  parameter int MEM_TIMEOUT = 0
) (
  input logic               CLK_32M,
  input logic               RESET_N,
  bg_rom_responder_if.slave bus
);

  localparam int TO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0]   TO_LAST   = (MEM_TIMEOUT > 0) ? TO_W'(MEM_TIMEOUT - 1) : '0;
  localparam logic [TO_W-1:0]   TO_MAX    = '1;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic              sel_b_q, sel_b_d;    // channel owning the in-flight read
  logic              last_b_q, last_b_d;  // last channel completed (1 = B)
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic [31:0]       data_a_q, data_a_d;
  logic [31:0]       data_b_q, data_b_d;
  logic              busy_q, busy_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic              pend_a, pend_b, pick_b;
  logic [ADDR_W-1:0] pick_addr;
  logic              hit;
  logic [31:0]       hit_data;
  logic              cmpl;
  logic              cmpl_b;
  logic [31:0]       cmpl_data;

  // A channel is pending while its toggle differs from our ack.
  assign pend_a = bus.sdr_req_a ^ ack_a_q;
  assign pend_b = bus.sdr_req_b ^ ack_b_q;
  // On a tie, serve whichever channel was not served last.
  assign pick_b    = pend_b & (~pend_a | ~last_b_q);
  assign pick_addr = (pick_b ? bus.sdr_addr_b : bus.sdr_addr_a) & WORD_MASK;

`ifdef BG_ROM_RESPONDER_HIT_CACHE_EN
  logic              tag_vld_a_q, tag_vld_a_d, tag_vld_b_q, tag_vld_b_d;
  logic [ADDR_W-1:0] tag_addr_a_q, tag_addr_a_d, tag_addr_b_q, tag_addr_b_d;
  logic [31:0]       tag_data_a_q, tag_data_a_d, tag_data_b_q, tag_data_b_d;
  logic [ADDR_W-1:0] tag_wr_addr;

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    if (pick_b) begin
      hit      = tag_vld_b_q && (tag_addr_b_q == pick_addr);
      hit_data = tag_data_b_q;
    end else begin
      hit      = tag_vld_a_q && (tag_addr_a_q == pick_addr);
      hit_data = tag_data_a_q;
    end
  end

  // Hits complete from IDLE using the live address; memory completions use the issued one.
  assign tag_wr_addr = (state_q == S_IDLE) ? pick_addr : mem_addr_q;

  always_comb begin
    tag_vld_a_d  = tag_vld_a_q;
    tag_vld_b_d  = tag_vld_b_q;
    tag_addr_a_d = tag_addr_a_q;
    tag_addr_b_d = tag_addr_b_q;
    tag_data_a_d = tag_data_a_q;
    tag_data_b_d = tag_data_b_q;
    if (cmpl) begin
      if (cmpl_b) begin
        tag_vld_b_d  = 1'b1;
        tag_addr_b_d = tag_wr_addr;
        tag_data_b_d = cmpl_data;
      end else begin
        tag_vld_a_d  = 1'b1;
        tag_addr_a_d = tag_wr_addr;
        tag_data_a_d = cmpl_data;
      end
    end
  end

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      tag_vld_a_q  <= 1'b0;
      tag_vld_b_q  <= 1'b0;
      tag_addr_a_q <= '0;
      tag_addr_b_q <= '0;
      tag_data_a_q <= '0;
      tag_data_b_q <= '0;
    end else begin
      tag_vld_a_q  <= tag_vld_a_d;
      tag_vld_b_q  <= tag_vld_b_d;
      tag_addr_a_q <= tag_addr_a_d;
      tag_addr_b_q <= tag_addr_b_d;
      tag_data_a_q <= tag_data_a_d;
      tag_data_b_q <= tag_data_b_d;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d    = state_q;
    sel_b_d    = sel_b_q;
    last_b_d   = last_b_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    ack_a_d    = ack_a_q;
    ack_b_d    = ack_b_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    to_cnt_d   = to_cnt_q;
    cmpl       = 1'b0;
    cmpl_b     = sel_b_q;
    cmpl_data  = bus.mem_dout;

    unique case (state_q)
      S_IDLE: begin
        if (pend_a || pend_b) begin
          if (hit) begin
            cmpl      = 1'b1;
            cmpl_b    = pick_b;
            cmpl_data = hit_data;
          end else begin
            mem_addr_d = pick_addr;
            mem_req_d  = 1'b1;
            sel_b_d    = pick_b;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // mem_dv without a grant here is stray and ignored.
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          to_cnt_d  = '0;
          if (bus.mem_dv) cmpl = 1'b1;
          else            state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_dv) begin
          cmpl = 1'b1;
        end else if ((MEM_TIMEOUT > 0) && (to_cnt_q == TO_LAST)) begin
          cmpl      = 1'b1;
          cmpl_data = '0;
        end else if (to_cnt_q != TO_MAX) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Data and ack move on the same edge so ack == req always implies valid data.
    if (cmpl) begin
      state_d  = S_IDLE;
      last_b_d = cmpl_b;
      if (cmpl_b) begin
        data_b_d = cmpl_data;
        ack_b_d  = bus.sdr_req_b;
      end else begin
        data_a_d = cmpl_data;
        ack_a_d  = bus.sdr_req_a;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      sel_b_q    <= 1'b0;
      last_b_q   <= 1'b1;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      busy_q     <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_b_q    <= sel_b_d;
      last_b_q   <= last_b_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      busy_q     <= busy_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign bus.sdr_ack_a  = ack_a_q;
  assign bus.sdr_ack_b  = ack_b_q;
  assign bus.sdr_data_a = data_a_q;
  assign bus.sdr_data_b = data_b_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bg_rom_responder.sv
// Purpose: directed self-checking bench for bg_rom_responder with a completion scoreboard.
// Latency: checks mem_req 1 cycle after toggle and ack/data 1 cycle after mem_dv.
// Backpressure: bench plays the SDRAM controller, choosing grant and data-valid timing.
module tb_bg_rom_responder;
  localparam int ADDR_W = 25;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  bg_rom_responder_if #(.ADDR_W(ADDR_W)) bus ();

  bg_rom_responder #(.ADDR_W(ADDR_W), .MEM_TIMEOUT(8)) u_dut (
    .CLK_32M (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ch;    // 1 = channel B
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Leaves time 1 unit after a rising edge: outputs settled, inputs safe to drive.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic ch, input logic [31:0] d);
    exp_t e;
    e.ch   = ch;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic rd_a(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bus.sdr_addr_a = a;
    bus.sdr_req_a  = ~bus.sdr_req_a;
    push(1'b0, d);
  endtask

  task automatic rd_b(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bus.sdr_addr_b = a;
    bus.sdr_req_b  = ~bus.sdr_req_b;
    push(1'b1, d);
  endtask

  task automatic expect_done();
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.ch) begin
        chk("ack_b", 32'(bus.sdr_ack_b), 32'(bus.sdr_req_b));
        chk("data_b", bus.sdr_data_b, e.data);
      end else begin
        chk("ack_a", 32'(bus.sdr_ack_a), 32'(bus.sdr_req_a));
        chk("data_a", bus.sdr_data_a, e.data);
      end
    end
  endtask

  // Called just after the edge that raised mem_req. gnt_wait: edges with mem_req held
  // before the grant; dv_gap: edges from grant to data valid (0 = same cycle).
  task automatic serve(input logic [ADDR_W-1:0] exp_addr, input int gnt_wait,
                       input int dv_gap, input logic [31:0] d);
    chk("mem_req_up", 32'(bus.mem_req), 32'd1);
    chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
    repeat (gnt_wait) begin
      tick();
      chk("mem_req_hold", 32'(bus.mem_req), 32'd1);
      chk("mem_addr_hold", 32'(bus.mem_addr), 32'(exp_addr));
    end
    bus.mem_gnt = 1'b1;
    if (dv_gap == 0) begin
      bus.mem_dv   = 1'b1;
      bus.mem_dout = d;
    end
    tick();
    bus.mem_gnt = 1'b0;
    bus.mem_dv  = 1'b0;
    if (dv_gap > 0) begin
      chk("mem_req_drop", 32'(bus.mem_req), 32'd0);
      chk("busy_wait", 32'(bus.busy), 32'd1);
      tick(dv_gap - 1);
      bus.mem_dv   = 1'b1;
      bus.mem_dout = d;
      tick();
      bus.mem_dv = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.sdr_req_a  = 1'b0;
    bus.sdr_req_b  = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_dv     = 1'b0;
    sb.delete();
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.sdr_addr_a = '0;
    bus.sdr_addr_b = '0;
    bus.sdr_req_a  = 1'b0;
    bus.sdr_req_b  = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_dv     = 1'b0;
    bus.mem_dout   = '0;
    rst_n          = 1'b0;
    tick(2);

    // Reset values
    chk("rst_ack_a", 32'(bus.sdr_ack_a), 32'd0);
    chk("rst_ack_b", 32'(bus.sdr_ack_b), 32'd0);
    chk("rst_data_a", bus.sdr_data_a, 32'd0);
    chk("rst_data_b", bus.sdr_data_b, 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;

    // Single A read, unaligned byte address
    rd_a(25'h0001236, 32'hDEADBEEF);
    tick();
    serve(25'h0001234, 2, 4, 32'hDEADBEEF);
    expect_done();
    chk("a_only_ack_b", 32'(bus.sdr_ack_b), 32'd0);
    chk("a_only_data_b", bus.sdr_data_b, 32'd0);
    chk("a_only_busy", 32'(bus.busy), 32'd0);

    // Stray mem_dv in IDLE
    bus.mem_dv   = 1'b1;
    bus.mem_dout = 32'h55555555;
    tick();
    bus.mem_dv = 1'b0;
    chk("stray_idle_ack_a", 32'(bus.sdr_ack_a), 32'd1);
    chk("stray_idle_data_a", bus.sdr_data_a, 32'hDEADBEEF);
    chk("stray_idle_mem_req", 32'(bus.mem_req), 32'd0);
    chk("stray_idle_busy", 32'(bus.busy), 32'd0);

    // Simultaneous pair after reset: A first, B on the very next edge
    do_reset();
    rd_a(25'h0000200, 32'hA0A0A0A0);
    rd_b(25'h0000300, 32'hB0B0B0B0);
    tick();
    serve(25'h0000200, 1, 2, 32'hA0A0A0A0);
    expect_done();
    chk("pair1_b_pending", 32'(bus.sdr_ack_b), 32'd0);
    tick();
    serve(25'h0000300, 0, 1, 32'hB0B0B0B0);
    expect_done();

    // Grant and data valid in the same cycle on A
    rd_a(25'h0000600, 32'h600D600D);
    tick();
    chk("same_cyc_busy", 32'(bus.busy), 32'd1);
    serve(25'h0000600, 1, 0, 32'h600D600D);
    expect_done();
    chk("same_cyc_busy_drop", 32'(bus.busy), 32'd0);

    // A served last, so the next simultaneous pair goes B first
    rd_b(25'h0000508, 32'h88888888);
    rd_a(25'h0000404, 32'h44444444);
    tick();
    serve(25'h0000508, 0, 1, 32'h88888888);
    expect_done();
    tick();
    serve(25'h0000404, 0, 1, 32'h44444444);
    expect_done();

    // Stray mem_dv in ISSUE (no grant yet)
    rd_b(25'h0000700, 32'h77777777);
    tick();
    bus.mem_dv   = 1'b1;
    bus.mem_dout = 32'hBADBAD00;
    tick();
    bus.mem_dv = 1'b0;
    chk("stray_issue_ack_b", 32'(bus.sdr_ack_b), 32'(!bus.sdr_req_b));
    serve(25'h0000700, 0, 1, 32'h77777777);
    expect_done();

    // Timeout: WAIT entered on the grant edge, completion 8 edges later with zero data
    rd_b(25'h0000800, 32'h00000000);
    tick();
    chk("to_mem_req", 32'(bus.mem_req), 32'd1);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    tick(7);
    chk("to_early_ack_b", 32'(bus.sdr_ack_b), 32'(!bus.sdr_req_b));
    chk("to_early_busy", 32'(bus.busy), 32'd1);
    tick();
    expect_done();
    chk("to_busy_drop", 32'(bus.busy), 32'd0);

    // A reads 0x100 twice
    rd_a(25'h0000100, 32'hCAFEF00D);
    tick();
    serve(25'h0000100, 0, 2, 32'hCAFEF00D);
    expect_done();
    rd_a(25'h0000100, 32'hCAFEF00D);
    tick();
`ifdef BG_ROM_RESPONDER_HIT_CACHE_EN
    chk("hit_no_mem_req", 32'(bus.mem_req), 32'd0);
    expect_done();
`else
    serve(25'h0000100, 0, 2, 32'hCAFEF00D);
    expect_done();
`endif

    // Reset during WAIT, then a late mem_dv
    rd_b(25'h0000900, 32'h99999999);
    tick();
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    chk("rstw_busy", 32'(bus.busy), 32'd1);
    rst_n         = 1'b0;
    bus.sdr_req_a = 1'b0;
    bus.sdr_req_b = 1'b0;
    sb.delete();
    tick();
    rst_n        = 1'b1;
    bus.mem_dv   = 1'b1;
    bus.mem_dout = 32'h12345678;
    tick();
    bus.mem_dv = 1'b0;
    tick();
    chk("rstw_ack_a", 32'(bus.sdr_ack_a), 32'd0);
    chk("rstw_ack_b", 32'(bus.sdr_ack_b), 32'd0);
    chk("rstw_data_a", bus.sdr_data_a, 32'd0);
    chk("rstw_data_b", bus.sdr_data_b, 32'd0);
    chk("rstw_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rstw_busy_low", 32'(bus.busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
